// File: rtl/div_seq.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) with go/done handshake.
// Radix-2 restoring shift-subtract core, one quotient bit per cycle, plus a one-entry result cache.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        sign,
  input  logic [31:0] n,
  input  logic [31:0] d,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] rem_q, quo_q, dmag_q;
  logic        negq_q, negr_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] quot_q, rmdr_q;

  logic        cache_vld_q;
  logic [31:0] cache_n_q, cache_d_q, cache_quot_q, cache_rmdr_q;
  logic        cache_sign_q;

  logic [32:0] rem_sh_d, trial_d;
  logic [31:0] n_mag_d, d_mag_d;
  logic        cache_hit_d, ovf_d;

  // Shift the next dividend bit into the partial remainder, then try subtracting the divisor.
  assign rem_sh_d    = {rem_q, quo_q[31]};
  assign trial_d     = rem_sh_d - {1'b0, dmag_q};
  assign n_mag_d     = (sign && n[31]) ? -n : n;
  assign d_mag_d     = (sign && d[31]) ? -d : d;
  assign ovf_d       = sign && (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
  assign cache_hit_d = cache_vld_q && (n == cache_n_q) && (d == cache_d_q) && (sign == cache_sign_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= '0;
      rmdr_q      <= '0;
      cache_vld_q <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            busy_q <= 1'b1;
            if (cache_hit_d) begin
              quot_q  <= cache_quot_q;
              rmdr_q  <= cache_rmdr_q;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (d == 32'd0) begin
              quot_q  <= 32'hFFFF_FFFF;
              rmdr_q  <= n;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (ovf_d) begin
              quot_q  <= 32'h8000_0000;
              rmdr_q  <= 32'd0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= n_mag_d;
              dmag_q  <= d_mag_d;
              negq_q  <= sign & (n[31] ^ d[31]);
              negr_q  <= sign & n[31];
              cnt_q   <= 5'd31;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!go) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // A negative trial means the divisor did not fit: keep the shifted remainder.
            if (!trial_d[32]) begin
              rem_q <= trial_d[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end else begin
              rem_q <= rem_sh_d[31:0];
              quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (!go) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            quot_q  <= negq_q ? -quo_q : quo_q;
            rmdr_q  <= negr_q ? -rem_q : rem_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cache_vld_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the cache payload has no reset; the valid bit alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (state_q == S_DONE) begin
      cache_n_q    <= n;
      cache_d_q    <= d;
      cache_sign_q <= sign;
      cache_quot_q <= quot_q;
      cache_rmdr_q <= rmdr_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rmdr_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model with a cache/latency model,
// directed corner cases followed by randomized operations.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset, go, sign;
  logic [31:0] n, d;
  logic        busy, done;
  logic [31:0] quotient, remainder;

  div_seq dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .sign      (sign),
    .n         (n),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle, maintained by the stimulus side.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done;
  logic [31:0] exp_q, exp_r;

  // Model of the one-entry cache.
  bit          c_valid = 1'b0;
  logic [31:0] c_n, c_d;
  logic        c_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("quotient", quotient, exp_q);
      check("remainder", remainder, exp_r);
    end
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  function automatic int expected_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
    bit hit;
    hit = c_valid && a == c_n && b == c_d && s == c_s;
    if (hit || b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Issue one operation; go is dropped at cycle abort_at (0 = never). seen = cycle of done, 0 if none.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int abort_at, output int seen);
    logic [31:0] eq, er;
    int lat;
    model(a, b, s, eq, er);
    lat = expected_latency(a, b, s);
    n = a; d = b; sign = s; go = 1'b1;
    seen = 0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      exp_busy = 1'b1;
      exp_done = (k == lat);
      if (k == lat) begin exp_q = eq; exp_r = er; end
      if (done && seen == 0) seen = k;
      if (abort_at != 0 && abort_at < lat && k == abort_at) begin
        go = 1'b0;
        @(posedge clk); #1;
        exp_busy = 1'b0; exp_done = 1'b0;
        if (done && seen == 0) seen = k + 1;
        return;
      end
      if (k == lat) go = 1'b0;
    end
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b0;
    c_valid = 1'b1; c_n = a; c_d = b; c_s = s;
  endtask

  // Start a full-length operation and assert reset in cycle at.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] b, input logic s, input int at);
    n = a; d = b; sign = s; go = 1'b1;
    for (int k = 1; k <= at; k++) begin
      @(posedge clk); #1;
      exp_busy = 1'b1; exp_done = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_q = '0; exp_r = '0;
    c_valid = 1'b0;
    reset = 1'b0; go = 1'b0;
  endtask

  initial begin
    logic [31:0] mq, mr, ra, rb, last_a, last_b;
    logic        rs, last_s;
    int seen, kind, ab;

    // Pin the reference model against hand-computed values.
    model(32'd100, 32'd7, 1'b0, mq, mr);
    check("model_u_q", mq, 32'd14);          check("model_u_r", mr, 32'd2);
    model(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr);
    check("model_s_q", mq, 32'hFFFF_FFFD);   check("model_s_r", mr, 32'hFFFF_FFFF);
    model(32'd5, 32'd0, 1'b1, mq, mr);
    check("model_dz_q", mq, 32'hFFFF_FFFF);  check("model_dz_r", mr, 32'd5);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mq, mr);
    check("model_ovu_q", mq, 32'd0);         check("model_ovu_r", mr, 32'h8000_0000);
    model(32'd1000, 32'd33, 1'b1, mq, mr);
    check("model_c_q", mq, 32'd30);          check("model_c_r", mr, 32'd10);

    reset = 1'b1; go = 1'b0; sign = 1'b0; n = '0; d = '0;
    @(posedge clk); #1;
    exp_busy = 1'b0; exp_done = 1'b0; exp_q = '0; exp_r = '0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(32'd100, 32'd7, 1'b0, 0, seen);                  check("lat_unsigned", seen, 34);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, seen);            check("lat_signed", seen, 34);
    do_op(32'd5, 32'd0, 1'b0, 0, seen);                    check("lat_div0", seen, 1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, seen);    check("lat_ovf", seen, 1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, seen);    check("lat_ovf_unsigned", seen, 34);
    do_op(32'd1000, 32'd33, 1'b1, 0, seen);                check("lat_cache_fill", seen, 34);
    check("q_1000_33", quotient, 32'd30);
    do_op(32'd1000, 32'd33, 1'b1, 0, seen);                check("lat_cache_hit", seen, 1);
    check("r_1000_33_hit", remainder, 32'd10);
    do_op(32'd1000, 32'd34, 1'b1, 0, seen);                check("lat_cache_miss", seen, 34);

    // Abort in CALC and in FIX: no done, outputs held, cache keeps 1000/34.
    do_op(32'd1000, 32'd35, 1'b1, 10, seen);               check("abort_calc_done", seen, 0);
    do_op(32'd1000, 32'd35, 1'b1, 33, seen);               check("abort_fix_done", seen, 0);
    do_op(32'd1000, 32'd34, 1'b1, 0, seen);                check("lat_after_abort_hit", seen, 1);
    do_op(32'd1000, 32'd35, 1'b1, 0, seen);                check("lat_after_abort", seen, 34);

    // Reset mid-CALC clears outputs and invalidates the cache.
    reset_mid(32'd1000, 32'd36, 1'b1, 20);
    @(posedge clk); #1;
    do_op(32'd1000, 32'd35, 1'b1, 0, seen);                check("lat_after_reset", seen, 34);

    // Reset and go together: reset wins, block stays idle.
    n = 32'd9; d = 32'd3; sign = 1'b0; go = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    exp_q = '0; exp_r = '0; c_valid = 1'b0;
    reset = 1'b0; go = 1'b0;
    @(posedge clk); #1;

    last_a = 32'd1000; last_b = 32'd35; last_s = 1'b1;
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      ab = 0;
      case (kind)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = last_a; rb = last_b; rs = last_s; end
        3: ab = $urandom_range(1, 33);
        4: rb = $urandom_range(1, 3);
        default: ;
      endcase
      do_op(ra, rb, rs, ab, seen);
      if (ab == 0) begin last_a = ra; last_b = rb; last_s = rs; end
      if (($urandom_range(0, 3)) == 0) begin
        @(posedge clk); #1;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divider sequencer for the execute stage, covering RV32M DIV, DIVU, REM and REMU. It uses the same go/done handshake as the multiplier, so the execute stage holds off with `go & ~done` and advances on `done`. Internally it is a four-state FSM around a radix-2 restoring shift-subtract core. It also has a one-entry result cache, so a DIV followed by a REM on the same operands completes in one cycle.

## Interface
- No parameters (width fixed at 32).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `go`  in  1  request; held high with stable operands until `done`.
- `sign`  in  1  1 selects signed operation (DIV/REM), 0 selects unsigned (DIVU/REMU).
- `n`  in  32  dividend.
- `d`  in  32  divisor.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse; `quotient` and `remainder` are valid in the same cycle.
- `quotient`  out  32  registered quotient; holds its value until the next completion.
- `remainder`  out  32  registered remainder; holds its value until the next completion.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state goes to IDLE. `done`, `busy`, `quotient` and `remainder` go to 0. The cache valid bit is cleared.
- **IDLE with `go`=1, cache hit** (cache valid and {`n`,`d`,`sign`} equal to the cached values):
  - Load the cached results.
  - Next state DONE.
- **IDLE with `go`=1, divide by zero** (`d`==0):
  - `quotient` = 0xFFFFFFFF, `remainder` = `n`, for either value of `sign`.
  - Next state DONE.
- **IDLE with `go`=1, signed overflow** (`sign` & `n`==0x80000000 & `d`==0xFFFFFFFF):
  - `quotient` = 0x80000000, `remainder` = 0.
  - Next state DONE.
- **IDLE with `go`=1, all other cases:**
  - Latch |n| and |d| (magnitudes taken only when `sign`=1).
  - Latch negq = `sign` & (n[31]^d[31]) and negr = `sign` & n[31].
  - Clear the partial remainder; load the iteration counter with 31.
  - Next state CALC.
- **CALC:** one quotient bit per cycle.
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − dmag using a 33-bit subtract.
  - If trial is non-negative, rem = trial and the quotient LSB = 1.
  - After 32 iterations (counter reaches 0), next state FIX.
- **FIX:**
  - `quotient` = negq ? −quo : quo.
  - `remainder` = negr ? −rem : rem.
  - Next state DONE.
- **DONE:**
  - `done` = 1 for this cycle only.
  - Write {`n`,`d`,`sign`,`quotient`,`remainder`} into the cache and set it valid.
  - Next state IDLE unconditionally; `go` is ignored in this cycle because the requester advances on this edge.
- **Abort:** `go`=0 in CALC or FIX means the requester was flushed.
  - Next state IDLE, no `done`.
  - The cache keeps its prior contents; outputs are not updated.
- **Out-of-contract input:** operand change while `go`=1 and `busy`=1 is forbidden. The result is undefined, but the FSM must still reach DONE.
- **Width rules:** negation is two's complement, modulo 2^32. The remainder always has the dividend's sign, or is zero.

## Timing
- Let cycle 0 be the cycle in which `go` is sampled in IDLE.
- **Normal path:** CALC in cycles 1–32, FIX in cycle 33, DONE (`done`=1) in cycle 34.
- **Cache-hit, divide-by-zero and overflow paths:** DONE in cycle 1.
- **Throughput:** after `done`, the earliest next `go` is sampled in the following cycle (IDLE). Minimum issue interval is 2 cycles on the fast paths and 35 cycles on the normal path.
- **`busy`** is registered: high from cycle 1 through the DONE cycle inclusive.
- **Reset** asserted in any state, including mid-CALC, returns the block to IDLE on that edge with every output 0 and the cache invalid.
- **Reset and `go` together:** reset wins.
- **Outputs:** `quotient` and `remainder` change only on entry to DONE.

## Test plan
- **Unsigned divide:** `n`=100, `d`=7, `sign`=0 → `done` in cycle 34, `quotient`=14, `remainder`=2, `busy` high for cycles 1–34.
- **Signed divide:** `n`=0xFFFFFFF9 (−7), `d`=2, `sign`=1 → `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1), at cycle 34.
- **Special cases** (each completes in cycle 1):
  - `n`=5, `d`=0 → `quotient`=0xFFFFFFFF, `remainder`=5.
  - `n`=0x80000000, `d`=0xFFFFFFFF, `sign`=1 → `quotient`=0x80000000, `remainder`=0.
  - Same operands with `sign`=0 → normal path, `quotient`=0, `remainder`=0x80000000.
- **Cache:** 1000/33 signed (34 cycles, `quotient`=30, `remainder`=10), then the same operands again → `done` in cycle 1 with identical results. Changing `d` to 34 takes the full 34 cycles again.
- **Abort:** drop `go` in cycle 10 of 1000/33 → IDLE next cycle, no `done` pulse, outputs unchanged. A fresh `go` with the same operands takes 34 cycles unless that entry was cached before.
- **Reset:** assert `reset` in cycle 20 of a CALC → next cycle `busy`=0, `done`=0, `quotient`=0, `remainder`=0. A repeat of a previously cached op takes 34 cycles.
